// File: rtl/qdot_accum_if.sv
// Operand/result bus for the fixed-point dot-product engine.
// The consumer side holds the master modport; the engine is the slave.
interface qdot_accum_if #(
   parameter int N     = 32,
   parameter int LEN_W = 4
);
   logic             start;
   logic [LEN_W-1:0] len;
   logic             in_valid;
   logic             in_ready;
   logic [N-1:0]     a;
   logic [N-1:0]     b;
   logic             out_valid;
   logic             out_ready;
   logic [N-1:0]     result;
   logic             ovr;
   logic             busy;

   modport master (
      output start, len, in_valid, a, b, out_ready,
      input  in_ready, out_valid, result, ovr, busy
   );

   modport slave (
      input  start, len, in_valid, a, b, out_ready,
      output in_ready, out_valid, result, ovr, busy
   );
endinterface

// File: rtl/qdot_accum.sv
// Sequential signed Q(N-Q).Q dot product with sign-magnitude truncating multiply.
// Define QDOT_SAT_EN to saturate the result on overflow; otherwise it wraps.
module qdot_accum #(
   parameter int Q     = 18,
   parameter int N     = 32,
   parameter int LEN_W = 4
) (
   input  logic         clk,
   input  logic         reset,
   qdot_accum_if.slave  bus
);
   localparam int AW = N + LEN_W;

   typedef enum logic [1:0] {IDLE, ACC, DRAIN, DONE} state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [LEN_W-1:0] r_len;
   logic [LEN_W-1:0] r_cnt;
   logic [AW-1:0]    r_acc;
   logic [N-1:0]     r_prod;
   logic             r_prod_vld;
   logic             r_ovr;
   logic [N-1:0]     r_result;
`ifdef QDOT_SAT_EN
   logic             r_povf_seen;
   logic             r_povf_neg;
`endif

   logic [N-1:0]     w_mag_a;
   logic [N-1:0]     w_mag_b;
   logic [2*N-1:0]   w_full;
   logic [N-1:0]     w_trunc;
   logic [N-1:0]     w_prod;
   logic             w_neg;
   logic             w_povf;
   logic             w_accept;
   logic             w_last;
   logic [AW-1:0]    w_prod_ext;
   logic [AW-1:0]    w_acc_sum;
   logic             w_range_ovf;
   logic [N-1:0]     w_final;

   assign w_mag_a = bus.a[N-1] ? -bus.a : bus.a;
   assign w_mag_b = bus.b[N-1] ? -bus.b : bus.b;
   assign w_full  = {{N{1'b0}}, w_mag_a} * {{N{1'b0}}, w_mag_b};
   assign w_trunc = N'(w_full >> Q);
   // Magnitude must fit in N-1 bits after the shift, hence the N-1+Q boundary.
   assign w_povf  = |(w_full >> (N - 1 + Q));
   assign w_neg   = bus.a[N-1] ^ bus.b[N-1];
   assign w_prod  = w_neg ? -w_trunc : w_trunc;

   assign w_accept    = (r_state == ACC) && bus.in_valid;
   assign w_last      = (r_cnt == r_len - 1'b1);
   assign w_prod_ext  = r_prod_vld ? {{LEN_W{r_prod[N-1]}}, r_prod} : '0;
   assign w_acc_sum   = r_acc + w_prod_ext;
   assign w_range_ovf = ~(&w_acc_sum[AW-1:N-1]) & (|w_acc_sum[AW-1:N-1]);

`ifdef QDOT_SAT_EN
   // A product overflow dominates: its sign sets the saturation direction.
   always_comb begin
      w_final = w_acc_sum[N-1:0];
      if (r_povf_seen)
         w_final = r_povf_neg ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
      else if (w_range_ovf)
         w_final = w_acc_sum[AW-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
   end
`else
   assign w_final = w_acc_sum[N-1:0];
`endif

   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (bus.start) w_state_next = (bus.len != '0) ? ACC : DONE;
         ACC:     if (w_accept && w_last) w_state_next = DRAIN;
         DRAIN:   w_state_next = DONE;
         DONE:    if (bus.out_ready) w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_len      <= '0;
         r_cnt      <= '0;
         r_acc      <= '0;
         r_prod     <= '0;
         r_prod_vld <= 1'b0;
         r_ovr      <= 1'b0;
         r_result   <= '0;
`ifdef QDOT_SAT_EN
         r_povf_seen <= 1'b0;
         r_povf_neg  <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: if (bus.start) begin
               r_len      <= bus.len;
               r_cnt      <= '0;
               r_acc      <= '0;
               r_prod_vld <= 1'b0;
               r_ovr      <= 1'b0;
               if (bus.len == '0) r_result <= '0;
`ifdef QDOT_SAT_EN
               r_povf_seen <= 1'b0;
               r_povf_neg  <= 1'b0;
`endif
            end
            ACC: begin
               // Product register is one pair behind the accept stream.
               r_acc      <= w_acc_sum;
               r_prod_vld <= w_accept;
               if (w_accept) begin
                  r_prod <= w_prod;
                  r_cnt  <= r_cnt + 1'b1;
                  if (w_povf) r_ovr <= 1'b1;
`ifdef QDOT_SAT_EN
                  if (w_povf && !r_povf_seen) begin
                     r_povf_seen <= 1'b1;
                     r_povf_neg  <= w_neg;
                  end
`endif
               end
            end
            DRAIN: begin
               r_acc      <= w_acc_sum;
               r_prod_vld <= 1'b0;
               r_result   <= w_final;
               r_ovr      <= r_ovr | w_range_ovf;
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = (r_state == ACC);
   assign bus.out_valid = (r_state == DONE);
   assign bus.busy      = (r_state != IDLE);
   assign bus.result    = r_result;
   assign bus.ovr       = r_ovr;
endmodule

// File: tb/tb_qdot_accum.sv
// Self-checking bench for qdot_accum: directed vectors plus randomized vectors
// checked against an arithmetic reference model.
module tb_qdot_accum;
   localparam int N     = 32;
   localparam int Q     = 18;
   localparam int LEN_W = 4;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   qdot_accum_if #(.N(N), .LEN_W(LEN_W)) u_if ();

   qdot_accum #(.Q(Q), .N(N), .LEN_W(LEN_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (u_if)
   );

   always #5 clk = ~clk;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] va [16];
   logic [31:0] vb [16];
   logic [31:0] exp_res;
   logic        exp_ovr;

   initial begin
      #500000;
      $display("FAIL global_timeout observed=running required=finished");
      $fatal(1, "bench timeout");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
      checks++;
      assert (obs === req) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
      end
   endtask

   // Reference: exact integer products, truncated toward zero, summed in 64 bits.
   task automatic model(input int len);
      longint      sum;
      logic        any_povf;
      logic        povf_neg;
      longint      sa, sb;
      logic [63:0] ma, mb, full, s;
      logic [31:0] t32, p32;
      logic        neg, range_bad;
      sum = 0; any_povf = 0; povf_neg = 0;
      for (int i = 0; i < len; i++) begin
         sa   = longint'($signed(va[i]));
         sb   = longint'($signed(vb[i]));
         ma   = (sa < 0) ? -sa : sa;
         mb   = (sb < 0) ? -sb : sb;
         full = ma * mb;
         t32  = full[49:18];
         neg  = (sa < 0) != (sb < 0);
         p32  = neg ? -t32 : t32;
         sum += longint'($signed(p32));
         if (full[63:49] != 0 && !any_povf) begin
            any_povf = 1;
            povf_neg = neg;
         end
      end
      range_bad = (sum > 64'sd2147483647) || (sum < -64'sd2147483648);
      exp_ovr   = any_povf || range_bad;
      s         = sum;
      exp_res   = s[31:0];
`ifdef QDOT_SAT_EN
      if (any_povf)       exp_res = povf_neg ? 32'h80000000 : 32'h7FFFFFFF;
      else if (range_bad) exp_res = (sum < 0) ? 32'h80000000 : 32'h7FFFFFFF;
`endif
   endtask

   function automatic logic [31:0] rnd_val();
      logic [23:0] s;
      if ($urandom_range(0, 7) == 0) return $urandom;
      s = 24'($urandom);
      return {{8{s[23]}}, s};
   endfunction

   task automatic run_vec(input string tag, input int len, input bit use_pat,
                          input bit [15:0] pat, input int stall);
      int idx = 0;
      int cyc = 0;
      bit v;
      model(len);
      u_if.start = 1'b1;
      u_if.len   = LEN_W'(len);
      @(negedge clk);
      u_if.start = 1'b0;
      chk({tag, "_busy"}, u_if.busy, 1);
      if (len == 0) begin
         chk({tag, "_zl_valid"}, u_if.out_valid, 1);
      end else begin
         chk({tag, "_in_ready"}, u_if.in_ready, 1);
         while (idx < len && cyc < 200) begin
            v = use_pat ? ((cyc < 16) ? pat[cyc] : 1'b1) : ($urandom_range(0, 3) != 0);
            u_if.in_valid = v;
            u_if.a        = v ? va[idx] : $urandom;
            u_if.b        = v ? vb[idx] : $urandom;
            u_if.start    = (cyc == 1);
            u_if.len      = '0;
            @(negedge clk);
            cyc++;
            if (v) idx++;
         end
         u_if.in_valid = 1'b0;
         u_if.start    = 1'b0;
         if (cyc >= 200) chk({tag, "_accept_timeout"}, 64'(idx), 64'(len));
         chk({tag, "_drain_valid"}, u_if.out_valid, 0);
         chk({tag, "_drain_ready"}, u_if.in_ready, 0);
         @(negedge clk);
         chk({tag, "_out_valid"}, u_if.out_valid, 1);
      end
      chk({tag, "_result"}, u_if.result, exp_res);
      chk({tag, "_ovr"}, u_if.ovr, exp_ovr);
      for (int s = 0; s < stall; s++) begin
         u_if.start = 1'b1;
         u_if.len   = 4'd1;
         @(negedge clk);
         chk({tag, "_stall_valid"}, u_if.out_valid, 1);
         chk({tag, "_stall_result"}, u_if.result, exp_res);
         chk({tag, "_stall_ovr"}, u_if.ovr, exp_ovr);
      end
      u_if.start     = 1'b0;
      u_if.out_ready = 1'b1;
      @(negedge clk);
      u_if.out_ready = 1'b0;
      chk({tag, "_idle_busy"}, u_if.busy, 0);
      chk({tag, "_idle_valid"}, u_if.out_valid, 0);
      $display("vec %s len=%0d result=%08h ovr=%0b exp=%08h/%0b",
               tag, len, u_if.result, u_if.ovr, exp_res, exp_ovr);
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_in_ready"}, u_if.in_ready, 0);
      chk({tag, "_out_valid"}, u_if.out_valid, 0);
      chk({tag, "_busy"}, u_if.busy, 0);
      chk({tag, "_result"}, u_if.result, 0);
      chk({tag, "_ovr"}, u_if.ovr, 0);
   endtask

   initial begin
      u_if.start = 0; u_if.len = '0; u_if.in_valid = 0;
      u_if.a = '0; u_if.b = '0; u_if.out_ready = 0;
      repeat (3) @(negedge clk);
      chk_reset_state("por");
      reset = 1'b0;
      @(negedge clk);

      va[0] = 32'h00040000; va[1] = 32'h00040000; va[2] = 32'h00040000;
      vb[0] = 32'h00080000; vb[1] = 32'hFFFE0000; vb[2] = 32'h00010000;
      run_vec("basic", 3, 1'b1, 16'hFFFF, 0);

      va[0] = 32'hFFFFFFFF; vb[0] = 32'h00020000;
      run_vec("trunc", 1, 1'b1, 16'hFFFF, 1);

      run_vec("zero_len", 0, 1'b1, 16'hFFFF, 2);

      va[0] = 32'h10000000; vb[0] = 32'h10000000;
      run_vec("prod_ovf", 1, 1'b1, 16'hFFFF, 0);

      va[0] = 32'h80000000; vb[0] = 32'h00040000;
      run_vec("neg_ovf", 1, 1'b1, 16'hFFFF, 0);

      for (int i = 0; i < 3; i++) begin
         va[i] = 32'h04000000; vb[i] = 32'h00400000;
      end
      run_vec("acc_ovf", 3, 1'b1, 16'hFFFF, 1);

      for (int i = 0; i < 4; i++) begin
         va[i] = rnd_val(); vb[i] = rnd_val();
      end
      run_vec("handshake", 4, 1'b1, 16'h0059, 5);

      for (int n = 0; n < 14; n++) begin
         int len;
         len = $urandom_range(0, 15);
         for (int i = 0; i < 16; i++) begin
            va[i] = rnd_val(); vb[i] = rnd_val();
         end
         run_vec($sformatf("rand%0d", n), len, 1'b0, 16'h0000, $urandom_range(0, 3));
      end

      va[0] = 32'h00040000; vb[0] = 32'h00040000;
      va[1] = 32'h00080000; vb[1] = 32'h00080000;
      u_if.start = 1'b1; u_if.len = 4'd4;
      @(negedge clk);
      u_if.start = 1'b0;
      u_if.in_valid = 1'b1; u_if.a = va[0]; u_if.b = vb[0];
      @(negedge clk);
      u_if.a = va[1]; u_if.b = vb[1];
      @(negedge clk);
      u_if.in_valid = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      chk_reset_state("mid_reset");
      reset = 1'b0;
      $display("vec mid_reset len=4 aborted after 2 pairs");
      @(negedge clk);
      run_vec("after_reset", 1, 1'b1, 16'hFFFF, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
